mpu_elementwise_stream: RTL and testbench

- Sequential, parametrised successor of the combinational 5x5 matrix subtractor.
- Streams one element pair (a, b) per cycle in row-major order and produces one result element per cycle.
- Operations: add or subtract, wrap or saturate, signed or unsigned.
- Sits between the MPU operand fetch and the result writeback. Exposes valid/ready handshakes, a per-matrix start/done protocol, a last-element marker and a sticky overflow flag.

---
 rtl/mpu_pkg.sv | 20 ++
 rtl/mpu_elem_alu.sv | 40 ++++
 rtl/mpu_elementwise_stream.sv | 106 ++++++++++
 tb/tb_mpu_elementwise_stream.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mpu_pkg.sv
// Shared types and defaults for the MPU element-wise datapath.
package mpu_pkg;

   localparam int unsigned MPU_WIDTH = 8;
   localparam int unsigned MPU_DIM   = 5;

   typedef enum logic [1:0] {
      OP_ADD_WRAP = 2'b00,
      OP_SUB_WRAP = 2'b01,
      OP_ADD_SAT  = 2'b10,
      OP_SUB_SAT  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_e;

endpackage

// File: rtl/mpu_elem_alu.sv
// Combinational element ALU: add/sub, wrap/saturate, signed/unsigned,
// with an overflow indication computed at WIDTH+1 bits.
module mpu_elem_alu
   import mpu_pkg::*;
#(
   parameter int unsigned WIDTH = MPU_WIDTH
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  op_e              op,
   input  logic             signed_mode,
   output logic [WIDTH-1:0] result,
   output logic             ovf
);

   localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] UMAX = {WIDTH{1'b1}};

   logic [WIDTH:0]   ext_a;
   logic [WIDTH:0]   ext_b;
   logic [WIDTH:0]   raw;
   logic             is_sub;
   logic             is_sat;
   logic [WIDTH-1:0] sat_val;

   always_comb begin
      ext_a   = signed_mode ? {a[WIDTH-1], a} : {1'b0, a};
      ext_b   = signed_mode ? {b[WIDTH-1], b} : {1'b0, b};
      is_sub  = (op == OP_SUB_WRAP) || (op == OP_SUB_SAT);
      is_sat  = (op == OP_ADD_SAT) || (op == OP_SUB_SAT);
      raw     = is_sub ? (ext_a - ext_b) : (ext_a + ext_b);
      // Signed: extra bit disagrees with sign bit. Unsigned: carry/borrow.
      ovf     = signed_mode ? (raw[WIDTH] ^ raw[WIDTH-1]) : raw[WIDTH];
      if (signed_mode) sat_val = raw[WIDTH] ? SMIN : SMAX;
      else             sat_val = is_sub ? '0 : UMAX;
      result  = (is_sat && ovf) ? sat_val : raw[WIDTH-1:0];
   end

endmodule

// File: rtl/mpu_elementwise_stream.sv
// Streaming element-wise matrix add/sub with valid/ready handshakes,
// per-matrix start/done, last marker and sticky overflow.
module mpu_elementwise_stream
   import mpu_pkg::*;
#(
   parameter int unsigned WIDTH      = MPU_WIDTH,
   parameter int unsigned MATRIX_DIM = MPU_DIM
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic             signed_mode,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_last,
   output logic             overflow,
   output logic             busy,
   output logic             done
);

   localparam int unsigned N     = MATRIX_DIM * MATRIX_DIM;
   localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N - 1);

   state_e           state;
   state_e           next_state;
   op_e              op_q;
   logic             signed_q;
   logic [CNT_W-1:0] cnt;
   logic             accept;
   logic             out_fire;
   logic             start_ok;
   logic [WIDTH-1:0] alu_result;
   logic             alu_ovf;

   mpu_elem_alu #(.WIDTH(WIDTH)) u_alu (
      .a           (in_a),
      .b           (in_b),
      .op          (op_q),
      .signed_mode (signed_q),
      .result      (alu_result),
      .ovf         (alu_ovf)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (start_ok) next_state = RUN;
         RUN:     if (accept && (cnt == LAST_IDX)) next_state = DRAIN;
         DRAIN:   if (out_fire && out_last) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Handshake decode; the output register may reload while it drains.
   always_comb begin
      busy     = (state != IDLE);
      in_ready = (state == RUN) && (!out_valid || out_ready);
      accept   = in_valid && in_ready;
      out_fire = out_valid && out_ready;
      start_ok = (state == IDLE) && start;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         op_q      <= OP_ADD_WRAP;
         signed_q  <= 1'b0;
         cnt       <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
         overflow  <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= (state == DRAIN) && out_fire && out_last;
         if (start_ok) begin
            op_q     <= op_e'(op);
            signed_q <= signed_mode;
            cnt      <= '0;
            overflow <= 1'b0;
         end
         if (accept) begin
            out_valid <= 1'b1;
            out_data  <= alu_result;
            out_last  <= (cnt == LAST_IDX);
            overflow  <= overflow | alu_ovf;
            if (cnt != LAST_IDX) cnt <= cnt + CNT_W'(1);
         end else if (out_fire) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mpu_elementwise_stream.sv
// Randomised and directed bench for mpu_elementwise_stream against an
// integer-range reference model with a pending-result queue.
module tb_mpu_elementwise_stream;

   localparam int W = 8;
   localparam int N = 25;

   logic         clock = 1'b0;
   logic         reset = 1'b1;
   logic         start = 1'b0;
   logic [1:0]   op = 2'b00;
   logic         signed_mode = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] in_a = '0;
   logic [W-1:0] in_b = '0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [W-1:0] out_data;
   logic         out_last;
   logic         overflow;
   logic         busy;
   logic         done;

   mpu_elementwise_stream #(.WIDTH(W), .MATRIX_DIM(5)) dut (
      .clock       (clock),
      .reset       (reset),
      .start       (start),
      .op          (op),
      .signed_mode (signed_mode),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_a        (in_a),
      .in_b        (in_b),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_last    (out_last),
      .overflow    (overflow),
      .busy        (busy),
      .done        (done)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [W-1:0] d;
      logic         l;
   } exp_t;

   exp_t         q[$];
   logic [W-1:0] got[$];
   int           vectors = 0;
   int           errors = 0;
   int           cyc = 0;
   int           done_cnt = 0;
   int           first_acc = 0;
   int           last_acc = 0;
   int           acc_cnt = 0;
   int           stall_cycles = 0;
   int           bp = 0;
   int           gap_max = 0;
   int           stall_at = -1;
   int           restart_at = -1;
   int           reset_at = -1;
   logic [W-1:0] sa[N];
   logic [W-1:0] sb[N];

   logic [1:0]   m_op = 2'b00;
   logic         m_sgn = 1'b0;
   logic         exp_busy = 1'b0;
   logic         exp_ovf = 1'b0;
   logic         exp_done = 1'b0;
   logic         prev_stall = 1'b0;
   logic [W-1:0] prev_d = '0;
   logic         prev_l = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: exact integer result, range-checked against the operand domain.
   function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [1:0] o, input logic s,
                                 output logic [W-1:0] r, output logic v);
      int xa, xb, x, lo, hi;
      xa = s ? int'($signed(a)) : int'(a);
      xb = s ? int'($signed(b)) : int'(b);
      x  = o[0] ? (xa - xb) : (xa + xb);
      lo = s ? -(1 << (W - 1)) : 0;
      hi = s ? ((1 << (W - 1)) - 1) : ((1 << W) - 1);
      v  = (x < lo) || (x > hi);
      if (o[1] && (x > hi))      r = W'(hi);
      else if (o[1] && (x < lo)) r = W'(lo);
      else                       r = W'(x);
   endfunction

   always @(posedge clock) cyc++;

   always @(posedge clock) begin
      #1;
      if (stall_cycles > 0) begin
         out_ready = 1'b0;
         stall_cycles--;
      end else begin
         out_ready = (bp != 0) ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
   end

   // Compare process: one check pass per cycle, away from the active edge.
   always @(negedge clock) begin
      exp_t         e;
      logic [W-1:0] r;
      logic         v;
      logic         nb, no, nd;
      if (reset) begin
         chk("rst_out_valid", int'(out_valid), 0);
         chk("rst_out_data", int'(out_data), 0);
         chk("rst_out_last", int'(out_last), 0);
         chk("rst_overflow", int'(overflow), 0);
         chk("rst_busy", int'(busy), 0);
         chk("rst_done", int'(done), 0);
         chk("rst_in_ready", int'(in_ready), 0);
         q.delete();
         exp_busy   = 1'b0;
         exp_ovf    = 1'b0;
         exp_done   = 1'b0;
         acc_cnt    = 0;
         prev_stall = 1'b0;
      end else begin
         chk("busy", int'(busy), int'(exp_busy));
         chk("overflow", int'(overflow), int'(exp_ovf));
         chk("done", int'(done), int'(exp_done));
         chk("out_valid", int'(out_valid), int'(q.size() != 0));
         chk("in_ready", int'(in_ready),
             int'(exp_busy && (acc_cnt < N) && ((q.size() == 0) || out_ready)));
         if (done) done_cnt++;
         if (out_valid && prev_stall) begin
            chk("hold_data", int'(out_data), int'(prev_d));
            chk("hold_last", int'(out_last), int'(prev_l));
         end
         nb = exp_busy;
         no = exp_ovf;
         nd = 1'b0;
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               vectors++;
               errors++;
               $display("FAIL out_pop: got data %0h expected no result", out_data);
            end else begin
               e = q.pop_front();
               chk("out_data", int'(out_data), int'(e.d));
               chk("out_last", int'(out_last), int'(e.l));
               if (e.l) begin
                  nd = 1'b1;
                  nb = 1'b0;
               end
            end
            got.push_back(out_data);
         end
         if (in_valid && in_ready) begin
            model(in_a, in_b, m_op, m_sgn, r, v);
            e.d = r;
            e.l = (acc_cnt == N - 1);
            q.push_back(e);
            acc_cnt++;
            no = no | v;
            if (acc_cnt == 1) first_acc = cyc;
            last_acc = cyc;
         end
         if (start && !exp_busy) begin
            m_op    = op;
            m_sgn   = signed_mode;
            nb      = 1'b1;
            acc_cnt = 0;
            no      = 1'b0;
         end
         exp_busy   = nb;
         exp_ovf    = no;
         exp_done   = nd;
         prev_stall = out_valid && !out_ready;
         prev_d     = out_data;
         prev_l     = out_last;
      end
   end

   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input int gap);
      int t;
      repeat (gap) begin
         @(posedge clock);
         #1;
      end
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      t        = 0;
      while (1) begin
         @(negedge clock);
         if (in_ready) break;
         t++;
         if (t > 200) begin
            vectors++;
            errors++;
            $display("FAIL send_timeout: got in_ready 0 expected 1 within 200 cycles");
            break;
         end
      end
      @(posedge clock);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic run_matrix(input logic [1:0] o, input logic s);
      int t;
      start       = 1'b1;
      op          = o;
      signed_mode = s;
      @(posedge clock);
      #1;
      start       = 1'b0;
      op          = 2'($urandom);
      signed_mode = 1'($urandom);
      for (int i = 0; i < N; i++) begin
         if (i == reset_at) begin
            reset        = 1'b1;
            stall_cycles = 0;
            @(posedge clock);
            #1;
            reset    = 1'b0;
            reset_at = -1;
            return;
         end
         if (i == stall_at) stall_cycles = 3;
         if (i == restart_at) begin
            start       = 1'b1;
            op          = ~o;
            signed_mode = ~s;
            @(posedge clock);
            #1;
            start = 1'b0;
            chk("restart_busy", int'(busy), 1);
         end
         send(sa[i], sb[i], (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0);
      end
      t = 0;
      while (busy && (t < 500)) begin
         @(posedge clock);
         #1;
         t++;
      end
      if (busy) begin
         vectors++;
         errors++;
         $display("FAIL drain_timeout: got busy 1 expected 0 within 500 cycles");
      end
      @(posedge clock);
      #1;
      stall_at   = -1;
      restart_at = -1;
   endtask

   task automatic fill_random();
      for (int i = 0; i < N; i++) begin
         sa[i] = W'($urandom);
         sb[i] = W'($urandom);
      end
   endtask

   initial begin
      int base, d0, nz;
      repeat (3) @(posedge clock);
      #1;
      reset = 1'b0;
      @(posedge clock);
      #1;

      // Unsigned SUB wrap, 3-5 everywhere.
      for (int i = 0; i < N; i++) begin
         sa[i] = 8'd3;
         sb[i] = 8'd5;
      end
      base = got.size();
      d0   = done_cnt;
      run_matrix(2'b01, 1'b0);
      chk("t1_count", got.size() - base, N);
      chk("t1_first", int'(got[base]), 'hFE);
      chk("t1_last", int'(got[base + N - 1]), 'hFE);
      chk("t1_overflow", int'(overflow), 1);
      chk("t1_done_once", done_cnt - d0, 1);
      chk("t1_throughput", last_acc - first_acc, N - 1);

      // Signed ADD saturate.
      fill_random();
      sa[0] = 8'd100; sb[0] = 8'd100;
      sa[1] = 8'h9C;  sb[1] = 8'h9C;
      sa[2] = 8'd10;  sb[2] = 8'hFD;
      base = got.size();
      run_matrix(2'b10, 1'b1);
      chk("t2_pos_sat", int'(got[base]), 'h7F);
      chk("t2_neg_sat", int'(got[base + 1]), 'h80);
      chk("t2_no_ovf_elem", int'(got[base + 2]), 7);
      chk("t2_overflow", int'(overflow), 1);

      // Unsigned SUB saturate, then a clean matrix clears overflow.
      fill_random();
      sa[0] = 8'd5; sb[0] = 8'd9;
      base = got.size();
      run_matrix(2'b11, 1'b0);
      chk("t3_floor", int'(got[base]), 0);
      chk("t3_overflow", int'(overflow), 1);
      for (int i = 0; i < N; i++) begin
         sa[i] = 8'd20;
         sb[i] = 8'd20;
      end
      base = got.size();
      run_matrix(2'b11, 1'b0);
      nz = 0;
      for (int i = 0; i < N; i++) if (got[base + i] != '0) nz++;
      chk("t3_all_zero", nz, 0);
      chk("t3_overflow_clear", int'(overflow), 0);

      // Backpressure stall at element 7.
      fill_random();
      stall_at = 7;
      base = got.size();
      run_matrix(2'($urandom), 1'($urandom));
      chk("t4_count", got.size() - base, N);

      // Ignored start/op change mid-matrix of an ADD wrap matrix.
      fill_random();
      restart_at = 12;
      base = got.size();
      d0   = done_cnt;
      run_matrix(2'b00, 1'b0);
      chk("t5_count", got.size() - base, N);
      chk("t5_add_wrap", int'(got[base + 20]), int'(W'(sa[20] + sb[20])));
      chk("t5_done_once", done_cnt - d0, 1);

      // Reset after element 10, then a fresh matrix.
      fill_random();
      reset_at = 10;
      d0 = done_cnt;
      run_matrix(2'b00, 1'b0);
      chk("t6_no_done", done_cnt - d0, 0);
      chk("t6_busy", int'(busy), 0);
      chk("t6_out_valid", int'(out_valid), 0);
      chk("t6_overflow", int'(overflow), 0);
      fill_random();
      gap_max = 2;
      bp      = 1;
      base    = got.size();
      d0      = done_cnt;
      run_matrix(2'b01, 1'b1);
      chk("t6_count", got.size() - base, N);
      chk("t6_done_once", done_cnt - d0, 1);

      // Random matrices with random gaps and backpressure.
      for (int m = 0; m < 8; m++) begin
         fill_random();
         base = got.size();
         run_matrix(2'($urandom), 1'($urandom));
         chk("rand_count", got.size() - base, N);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
